// File: rtl/ecdsa_pkg.sv
// ecdsa_pkg
//   Shared definitions for the ECDSA command sequencer: the sequencer FSM
//   state encoding, the STATUS/COMMAND bit positions, the CSR byte offsets
//   used by the AXI-lite register file, and the BRAM word stride.
package ecdsa_pkg;

  // Byte stride between consecutive 1024-bit BRAM words.
  localparam int unsigned WORD_BYTES = 32'd128;

  // COMMAND register bit that starts one operation.
  localparam int unsigned CMD_GO_BIT = 32'd0;

  // STATUS register bit positions.
  localparam int unsigned DONE_BIT  = 32'd0;
  localparam int unsigned BUSY_BIT  = 32'd1;
  localparam int unsigned ALIGN_BIT = 32'd2;

  // CSR byte offsets (COMMAND is write side, STATUS is read side of r0).
  localparam logic [7:0] CSR_COMMAND_OFS = 8'h00;
  localparam logic [7:0] CSR_STATUS_OFS  = 8'h00;
  localparam logic [7:0] CSR_RXADDR_OFS  = 8'h04;
  localparam logic [7:0] CSR_TXADDR_OFS  = 8'h08;

  // Sequencer FSM states, in the order a command walks through them.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_A    = 4'd1,
    LAT_A   = 4'd2,
    RD_B    = 4'd3,
    LAT_B   = 4'd4,
    START   = 4'd5,
    WAIT_DP = 4'd6,
    WR      = 4'd7,
    DONE    = 4'd8
  } seq_state_t;

endpackage

// File: rtl/ecdsa_cycle_counter.sv
// ecdsa_cycle_counter
//   Saturating cycle counter. Cleared by clr (which wins over en), advances
//   by one while en is high, sticks at all ones, and holds its value
//   whenever en is low so the last command's duration stays readable.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear to zero
//   en     in   count enable
//   count  out  CNT_W current (registered) count
module ecdsa_cycle_counter #(
  parameter int unsigned CNT_W = 32'd32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ecdsa_cmd_sequencer.sv
// ecdsa_cmd_sequencer
//   Runs one datapath operation per software command: reads operand A at
//   rx and operand B at rx+WORD_BYTES from BRAM, pulses dp_start, waits for
//   dp_done, writes the result to tx, then holds STATUS.done until the go
//   bit is cleared. Addresses are forced to word alignment; a misaligned
//   request still runs but raises STATUS.align_err.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   csr_cmd              COMMAND register, bit 0 = go (level)
//   csr_rxaddr/txaddr    operand A / result byte addresses
//   csr_status           {.., align_err, busy, done}
//   csr_cycles           cycles spent by the current / last command
//   mem_addr/din/we      BRAM port (registered), mem_dout 1-cycle read data
//   dp_start/dp_a/dp_b   datapath start pulse and held operands
//   dp_done/dp_result    datapath completion pulse and result
module ecdsa_cmd_sequencer #(
  parameter int unsigned DATA_W     = 32'd1024,
  parameter int unsigned ADDR_W     = 32'd17,
  parameter int unsigned WORD_BYTES = 32'd128,
  parameter int unsigned CNT_W      = 32'd32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           csr_cmd,
  input  logic [ADDR_W-1:0]     csr_rxaddr,
  input  logic [ADDR_W-1:0]     csr_txaddr,
  output logic [31:0]           csr_status,
  output logic [CNT_W-1:0]      csr_cycles,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  output logic [DATA_W/8-1:0]   mem_we,
  input  logic [DATA_W-1:0]     mem_dout,
  output logic                  dp_start,
  output logic [DATA_W-1:0]     dp_a,
  output logic [DATA_W-1:0]     dp_b,
  input  logic                  dp_done,
  input  logic [DATA_W-1:0]     dp_result
);

  import ecdsa_pkg::*;

  localparam int unsigned       WE_W       = DATA_W / 32'd8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(WORD_BYTES - 32'd1);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(WORD_BYTES);

  // Clear the sub-word offset bits of a byte address.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ALIGN_MASK;
  endfunction

  seq_state_t        state_r, state_s;
  logic [ADDR_W-1:0] rx_r, rx_s, tx_r, tx_s;
  logic              align_r, align_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              accept_s;
  logic              go_s;

  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic              mem_we_r, mem_we_s;
  logic              dp_start_r, dp_start_s;
  logic [DATA_W-1:0] dp_a_r, dp_b_r, wbuf_r;

  logic              cnt_en_s;
  logic [CNT_W-1:0]  cnt_s;
  logic [31:0]       status_s;

  // Only the go bit of COMMAND matters; the rest are don't-care.
  logic              unused_cmd_s;
  assign unused_cmd_s = ^csr_cmd[31:1];
  assign go_s         = csr_cmd[CMD_GO_BIT];

  // Next-state and control-register logic.
  always_comb begin
    state_s  = state_r;
    rx_s     = rx_r;
    tx_s     = tx_r;
    align_s  = align_r;
    busy_s   = busy_r;
    done_s   = done_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (go_s) begin
          accept_s = 1'b1;
          rx_s     = word_align(csr_rxaddr);
          tx_s     = word_align(csr_txaddr);
          align_s  = (|(csr_rxaddr & ALIGN_MASK)) || (|(csr_txaddr & ALIGN_MASK));
          busy_s   = 1'b1;
          done_s   = 1'b0;
          state_s  = RD_A;
        end else begin
          state_s  = IDLE;
        end
      end
      RD_A:  state_s = LAT_A;
      LAT_A: state_s = RD_B;
      RD_B:  state_s = LAT_B;
      LAT_B: state_s = START;
      START: state_s = WAIT_DP;
      WAIT_DP: begin
        if (dp_done) begin
          state_s = WR;
        end else begin
          state_s = WAIT_DP;
        end
      end
      WR: begin
        state_s = DONE;
        busy_s  = 1'b0;
        done_s  = 1'b1;
      end
      DONE: begin
        // Level-sensitive go: stay here until software drops it, so one
        // write of 1 yields exactly one operation.
        if (!go_s) begin
          state_s = IDLE;
          done_s  = 1'b0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Output decode from the state being entered so the BRAM/datapath
  // controls are registered and line up with the state itself.
  always_comb begin
    mem_addr_s = '0;
    mem_we_s   = 1'b0;
    dp_start_s = 1'b0;
    case (state_s)
      RD_A:  mem_addr_s = rx_s;
      RD_B:  mem_addr_s = rx_s + STRIDE;  // wraps modulo 2^ADDR_W
      START: dp_start_s = 1'b1;
      WR: begin
        mem_addr_s = tx_s;
        mem_we_s   = 1'b1;
      end
      default: begin
        mem_addr_s = '0;
        mem_we_s   = 1'b0;
        dp_start_s = 1'b0;
      end
    endcase
  end

  // FSM state and control/output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= IDLE;
      rx_r       <= '0;
      tx_r       <= '0;
      align_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mem_addr_r <= '0;
      mem_we_r   <= 1'b0;
      dp_start_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      rx_r       <= rx_s;
      tx_r       <= tx_s;
      align_r    <= align_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      mem_addr_r <= mem_addr_s;
      mem_we_r   <= mem_we_s;
      dp_start_r <= dp_start_s;
    end
  end

  // Operand capture (BRAM data arrives in the LAT_* cycle) and result buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dp_a_r <= '0;
      dp_b_r <= '0;
      wbuf_r <= '0;
    end else begin
      dp_a_r <= (state_r == LAT_A) ? mem_dout : dp_a_r;
      dp_b_r <= (state_r == LAT_B) ? mem_dout : dp_b_r;
      wbuf_r <= ((state_r == WAIT_DP) && dp_done) ? dp_result : wbuf_r;
    end
  end

  // Counter runs over every working state, RD_A through WR.
  always_comb begin
    case (state_r)
      RD_A, LAT_A, RD_B, LAT_B, START, WAIT_DP, WR: cnt_en_s = 1'b1;
      default:                                      cnt_en_s = 1'b0;
    endcase
  end

  ecdsa_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk   (clk),
    .rst_n (resetn),
    .clr   (accept_s),
    .en    (cnt_en_s),
    .count (cnt_s)
  );

  // STATUS word assembled from the registered flags.
  always_comb begin
    status_s            = 32'd0;
    status_s[DONE_BIT]  = done_r;
    status_s[BUSY_BIT]  = busy_r;
    status_s[ALIGN_BIT] = align_r;
  end

  assign csr_status = status_s;
  assign csr_cycles = cnt_s;
  assign mem_addr   = mem_addr_r;
  assign mem_din    = wbuf_r;
  assign mem_we     = {WE_W{mem_we_r}};
  assign dp_start   = dp_start_r;
  assign dp_a       = dp_a_r;
  assign dp_b       = dp_b_r;

endmodule

// File: tb/tb_ecdsa_cmd_sequencer.sv
// tb_ecdsa_cmd_sequencer
//   Scoreboard bench: each command pushes its expected datapath operands,
//   BRAM write and completion status into queues; a monitor pops and
//   compares whenever the DUT starts the datapath, writes BRAM or raises
//   done. Expected values come from a word-level memory model.
module tb_ecdsa_cmd_sequencer;

  localparam int DW = 1024;
  localparam int AW = 17;
  localparam int CW = 32;
  localparam int NW = 1024;   // 2^17 bytes / 128 bytes per word

  typedef struct packed { logic [DW-1:0] a; logic [DW-1:0] b; } st_exp_t;
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
  typedef struct packed { logic [31:0] status; logic [CW-1:0] cycles; } dn_exp_t;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              preload = 1'b1;
  logic [31:0]       csr_cmd = 32'd0;
  logic [AW-1:0]     csr_rxaddr = '0;
  logic [AW-1:0]     csr_txaddr = '0;
  logic [31:0]       csr_status;
  logic [CW-1:0]     csr_cycles;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [DW/8-1:0]   mem_we;
  logic [DW-1:0]     mem_dout;
  logic              dp_start;
  logic [DW-1:0]     dp_a, dp_b;
  logic              dp_done;
  logic [DW-1:0]     dp_result;

  logic              stub_done;
  logic [DW-1:0]     stub_res;
  int                stub_cnt;
  int                stub_lat = 5;
  logic              inj_done = 1'b0;
  logic [DW-1:0]     inj_res = '0;

  logic [DW-1:0]     bram    [0:NW-1];
  logic [DW-1:0]     ref_mem [0:NW-1];

  st_exp_t q_start[$];
  wr_exp_t q_wr[$];
  dn_exp_t q_done[$];

  int  checks = 0;
  int  errors = 0;
  int  n_starts = 0;
  int  n_writes = 0;
  bit  prev_done = 1'b0;

  always #5 clk = ~clk;

  assign dp_done   = stub_done | inj_done;
  assign dp_result = inj_done ? inj_res : stub_res;

  ecdsa_cmd_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .csr_cmd    (csr_cmd),
    .csr_rxaddr (csr_rxaddr),
    .csr_txaddr (csr_txaddr),
    .csr_status (csr_status),
    .csr_cycles (csr_cycles),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout),
    .dp_start   (dp_start),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_done    (dp_done),
    .dp_result  (dp_result)
  );

  // BRAM model: 1-cycle read latency, byte-lane writes, one-shot preload.
  always @(posedge clk) begin
    if (preload) begin
      for (int w = 0; w < NW; w++) bram[w] <= ref_mem[w];
    end else begin
      for (int i = 0; i < DW/8; i++)
        if (mem_we[i]) bram[mem_addr[AW-1:7]][i*8 +: 8] <= mem_din[i*8 +: 8];
    end
    mem_dout <= bram[mem_addr[AW-1:7]];
  end

  // Stub datapath: returns a+b, dp_done rises stub_lat cycles after dp_start.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
      stub_res  <= '0;
    end else begin
      stub_done <= 1'b0;
      if (dp_start) begin
        stub_cnt <= stub_lat;
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          stub_done <= 1'b1;
          stub_res  <= dp_a + dp_b;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  task automatic monitor_step();
    st_exp_t s;
    wr_exp_t w;
    dn_exp_t d;
    if (!resetn) begin
      prev_done = 1'b0;
    end else begin
      if (dp_start) begin
        n_starts++;
        if (q_start.size() == 0) chk("unexpected_dp_start", 1, 0);
        else begin
          s = q_start.pop_front();
          chk("dp_a", dp_a, s.a);
          chk("dp_b", dp_b, s.b);
        end
      end
      if (mem_we != '0) begin
        n_writes++;
        if (q_wr.size() == 0) chk("unexpected_mem_write", 1, 0);
        else begin
          w = q_wr.pop_front();
          chk("wr_addr", DW'(mem_addr), DW'(w.addr));
          chk("wr_data", mem_din, w.data);
          chk("wr_we_all", DW'(&mem_we), 1);
        end
      end
      if (csr_status[0] && !prev_done) begin
        if (q_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = q_done.pop_front();
          chk("done_status", DW'(csr_status), DW'(d.status));
          chk("done_cycles", DW'(csr_cycles), DW'(d.cycles));
        end
      end
      prev_done = csr_status[0];
    end
  endtask

  // Reference: word-granular addresses, wrapping at the 128 KiB BRAM size.
  task automatic model(input int rx, input int tx, input int lat, input bit commit,
                       output logic [DW-1:0] a, output logic [DW-1:0] b,
                       output int wa, output bit al, output int cyc);
    int ra, rb;
    ra  = (rx / 128) * 128;
    rb  = (ra + 128) % 131072;
    wa  = (tx / 128) * 128;
    al  = ((rx % 128) != 0) || ((tx % 128) != 0);
    a   = ref_mem[ra / 128];
    b   = ref_mem[rb / 128];
    cyc = 7 + lat;
    if (commit) ref_mem[wa / 128] = a + b;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dp_start) seen = 1'b1;
    end
    if (!seen) chk("dp_start_timeout", 1, 0);
  endtask

  // One command; drop=1 clears go during WAIT_DP, else hold go for hold cycles.
  task automatic run_op(input int rx, input int tx, input int lat, input bit drop, input int hold);
    logic [DW-1:0] a, b;
    int wa, cyc, s0, w0;
    bit al, seen;
    logic [31:0] r;
    model(rx, tx, lat, 1'b1, a, b, wa, al, cyc);
    q_start.push_back('{a: a, b: b});
    q_wr.push_back('{addr: AW'(wa), data: a + b});
    q_done.push_back('{status: 32'd1 | (32'(al) << 2), cycles: CW'(cyc)});
    stub_lat = lat;
    r = $urandom();
    @(negedge clk);
    csr_rxaddr = AW'(rx);
    csr_txaddr = AW'(tx);
    csr_cmd    = r | 32'd1;
    @(negedge clk);
    chk("busy_status", DW'(csr_status), DW'(32'd2 | (32'(al) << 2)));
    if (drop) begin
      wait_start(seen);
      @(negedge clk);
      csr_cmd = r & ~32'd1;
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (csr_status[0]) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("done_timeout", 1, 0);
    if (drop) begin
      @(negedge clk);
      chk("done_pulse_1cyc", DW'(csr_status), DW'(32'(al) << 2));
    end else begin
      s0 = n_starts;
      w0 = n_writes;
      repeat (hold) @(negedge clk);
      chk("done_held", DW'(csr_status), DW'(32'd1 | (32'(al) << 2)));
      chk("no_restart_start", DW'(n_starts), DW'(s0));
      chk("no_restart_write", DW'(n_writes), DW'(w0));
      csr_cmd = r & ~32'd1;
      @(negedge clk);
      chk("idle_status", DW'(csr_status), DW'(32'(al) << 2));
    end
    chk("frozen_cycles", DW'(csr_cycles), DW'(cyc));
  endtask

  initial begin
    logic [DW-1:0] a, b;
    int wa, cyc, mism;
    bit al, seen;

    for (int w = 0; w < NW; w++)
      for (int k = 0; k < DW/32; k++) ref_mem[w][k*32 +: 32] = $urandom();
    ref_mem[0] = DW'(1);
    ref_mem[1] = DW'(2);

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    repeat (3) @(negedge clk);
    preload = 1'b0;
    chk("rst_status", DW'(csr_status), 0);
    chk("rst_cycles", DW'(csr_cycles), 0);
    chk("rst_we", DW'(mem_we), 0);
    chk("rst_dp_start", DW'(dp_start), 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", DW'(csr_status), 0);

    // 1 + 2 = 3, latency 5, go held 100 cycles after done.
    run_op(32'h00000, 32'h00100, 5, 1'b0, 100);
    chk("bram_0x100", bram[2], DW'(3));

    run_op(32'h1FF80, 32'h00400, 3, 1'b0, 2);   // operand B wraps to 0
    run_op(32'h00005, 32'h00083, 4, 1'b0, 1);   // misaligned
    run_op(32'h00200, 32'h00200, 2, 1'b0, 0);   // tx == rx
    run_op(32'h00300, 32'h00380, 1, 1'b0, 3);   // tx == rx + stride
    run_op(32'h00600, 32'h00700, 6, 1'b1, 0);   // go dropped in WAIT_DP

    // Reset during WAIT_DP: only the datapath start is expected.
    model(32'h00800, 32'h00900, 20, 1'b0, a, b, wa, al, cyc);
    q_start.push_back('{a: a, b: b});
    stub_lat = 20;
    @(negedge clk);
    csr_rxaddr = AW'(32'h00800);
    csr_txaddr = AW'(32'h00900);
    csr_cmd    = 32'd1;
    wait_start(seen);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_status", DW'(csr_status), 0);
    chk("mid_rst_cycles", DW'(csr_cycles), 0);
    chk("mid_rst_we", DW'(mem_we), 0);
    chk("mid_rst_addr", DW'(mem_addr), 0);
    chk("mid_rst_dp_start", DW'(dp_start), 0);
    chk("mid_rst_dp_a", dp_a, 0);
    chk("mid_rst_dp_b", dp_b, 0);
    chk("mid_rst_din", mem_din, 0);
    csr_cmd = 32'd0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    inj_done = 1'b1;
    for (int k = 0; k < DW/32; k++) inj_res[k*32 +: 32] = $urandom();
    @(negedge clk);
    inj_done = 1'b0;
    repeat (10) @(negedge clk);
    chk("late_done_ignored", DW'(csr_status), 0);
    chk("late_done_cycles", DW'(csr_cycles), 0);
    run_op(32'h00800, 32'h00900, 4, 1'b0, 2);

    // Randomized commands.
    for (int n = 0; n < 10; n++)
      run_op($urandom_range(0, 131071), $urandom_range(0, 131071),
             $urandom_range(1, 12), 1'($urandom_range(0, 1)), $urandom_range(0, 5));

    repeat (3) @(negedge clk);
    chk("queues_drained", DW'(q_start.size() + q_wr.size() + q_done.size()), 0);
    mism = 0;
    for (int w = 0; w < NW; w++) if (bram[w] !== ref_mem[w]) mism++;
    chk("bram_vs_model", DW'(mism), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
